// File: rtl/hi_lo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hi_lo_muldiv_unit
// Brief    : HI/LO register pair with an iterative radix-2 multiply/divide
//            engine (MULT/MULTU/DIV/DIVU) and independent MTHI/MTLO writes.
// Revision : 1.0 - initial release
// ============================================================================
module hi_lo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             op_start,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int              c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic              r_is_div;
  logic              r_neg_q;     // negate quotient / product
  logic              r_neg_r;     // negate remainder (dividend negative)
  logic [WIDTH-1:0]  r_a;         // raw dividend, needed for divide-by-zero HI
  logic [WIDTH-1:0]  r_acc;       // product high half / partial remainder
  logic [WIDTH-1:0]  r_q;         // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]  r_b;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic              r_done;

  // Operand magnitudes and signs; only MULT and DIV (op_code[0]==0) are signed
  logic              w_signed;
  logic              w_sa;
  logic              w_sb;
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;

  assign w_signed = ~op_code[0];
  assign w_sa     = w_signed & op_a[WIDTH-1];
  assign w_sb     = w_signed & op_b[WIDTH-1];
  assign w_mag_a  = w_sa ? -op_a : op_a;
  assign w_mag_b  = w_sb ? -op_b : op_b;

  // Multiply step: add multiplicand when the current multiplier bit is set
  logic [WIDTH:0]    w_sum;
  assign w_sum = r_q[0] ? ({1'b0, r_acc} + {1'b0, r_b}) : {1'b0, r_acc};

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  // The shifted value can exceed WIDTH bits, in which case it always fits.
  logic [WIDTH:0]    w_shift;
  logic              w_ge;
  logic [WIDTH-1:0]  w_diff;
  assign w_shift = {r_acc, r_q[WIDTH-1]};
  assign w_ge    = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_b);
  assign w_diff  = w_shift[WIDTH-1:0] - r_b;

  // Sign correction and result selection applied in FIN
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_prod_mag = {r_acc, r_q};
  assign w_prod     = r_neg_q ? -w_prod_mag : w_prod_mag;
  assign w_quo      = r_neg_q ? -r_q : r_q;
  assign w_rem      = r_neg_r ? -r_acc : r_acc;

  // Result mux: divide by zero yields all-ones quotient and the raw dividend
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b == '0) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> FIN after WIDTH steps
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (op_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == c_LAST) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (clk_enable) begin
      r_state <= w_state_nxt;
    end
  end

  // Engine datapath: latch operands at start, one radix-2 step per RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
    end else if (clk_enable) begin
      case (r_state)
        S_IDLE: begin
          if (op_start) begin
            r_is_div <= op_code[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_a      <= op_a;
            r_acc    <= '0;
            r_q      <= op_code[1] ? w_mag_a : w_mag_b;
            r_b      <= op_code[1] ? w_mag_b : w_mag_a;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
          if (r_is_div) begin
            r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO registers: direct writes only in IDLE, engine result in FIN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (clk_enable) begin
      if (r_state == S_IDLE) begin
        if (hi_we) r_hi <= hi_in;
        if (lo_we) r_lo <= lo_in;
      end else if (r_state == S_FIN) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  // Completion pulse, registered alongside the HI/LO write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
    end else if (clk_enable) begin
      r_done <= (r_state == S_FIN);
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule
`default_nettype wire
